// File: rtl/pong_pixel_pipe_if.sv
// Pong pixel compositor bus: sync/game inputs in, composed rgb out.
// master drives the pixel stream, slave is the compositor.
interface pong_pixel_pipe_if #(
  parameter int NUM_PADDLES = 2
);
  logic                      pixel_tick;
  logic                      frame_tick;
  logic [9:0]                x;
  logic [9:0]                y;
  logic                      video_on;
  logic [9:0]                ball_x;
  logic [9:0]                ball_y;
  logic [10*NUM_PADDLES-1:0] paddle_x;
  logic [10*NUM_PADDLES-1:0] paddle_y;
  logic [3:0]                ball_speed;
  logic                      hit_pulse;
  logic                      game_over;
  logic [11:0]               bg_pixel;
  logic [11:0]               game_over_pixel;
  logic [11:0]               text_rgb;
  logic                      text_on;
  logic [11:0]               rgb;

  modport master (
    output pixel_tick, frame_tick, x, y, video_on,
    output ball_x, ball_y, paddle_x, paddle_y,
    output ball_speed, hit_pulse, game_over,
    output bg_pixel, game_over_pixel, text_rgb, text_on,
    input  rgb
  );

  modport slave (
    input  pixel_tick, frame_tick, x, y, video_on,
    input  ball_x, ball_y, paddle_x, paddle_y,
    input  ball_speed, hit_pulse, game_over,
    input  bg_pixel, game_over_pixel, text_rgb, text_on,
    output rgb
  );
endinterface

// File: rtl/pong_pixel_pipe.sv
// Two-stage Pong pixel compositor: hit flags, then priority mux.
// Optional macro GAMEOVER_BLINK_EN blinks the game-over overlay.
module pong_pixel_pipe #(
  parameter int          NUM_PADDLES     = 2,
  parameter int          PADDLE_W        = 9,
  parameter int          PADDLE_H        = 73,
  parameter int          BALL_SCALE      = 1,
  parameter int          TOP_MARGIN      = 25,
  parameter int          WALL_W          = 32,
  parameter int          H_RES           = 640,
  parameter int          FLASH_FRAMES    = 6,
  parameter int          BLINK_FRAMES    = 30,
  parameter logic [11:0] WALL_COLOR      = 12'h89C,
  parameter logic [11:0] PADDLE_COLOR    = 12'h24F,
  parameter logic [11:0] HEADER_BG_COLOR = 12'h135,
  parameter logic [11:0] FLASH_COLOR     = 12'hFF0
) (
  input logic               clk,
  input logic               reset,
  pong_pixel_pipe_if.slave  bus
);

  localparam int BSZ = 8 * BALL_SCALE;
  localparam int SH  = (BALL_SCALE == 4) ? 2 :
                       (BALL_SCALE == 2) ? 1 : 0;

  logic [10:0] x11, y11;
  assign x11 = {1'b0, bus.x};
  assign y11 = {1'b0, bus.y};

  logic [NUM_PADDLES-1:0] pad_hit;

  for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_pad
    logic [10:0] px, py;
    assign px = {1'b0, bus.paddle_x[10*i +: 10]};
    assign py = {1'b0, bus.paddle_y[10*i +: 10]}
              + 11'(TOP_MARGIN);
    assign pad_hit[i] = (x11 >= px)
                     && (x11 <= px + 11'(PADDLE_W - 1))
                     && (y11 >= py)
                     && (y11 <= py + 11'(PADDLE_H - 1));
  end

  logic [9:0] dx, dy;
  logic       ball_sq;
  logic [2:0] rom_row, rom_col;
  assign dx      = bus.x - bus.ball_x;
  assign dy      = bus.y - bus.ball_y;
  assign ball_sq = (bus.x >= bus.ball_x)
                && (bus.y >= bus.ball_y)
                && (dx < 10'(BSZ))
                && (dy < 10'(BSZ));
  assign rom_row = 3'(dy >> SH);
  assign rom_col = 3'(dx >> SH);

  logic       hdr, wall;
  assign hdr  = bus.y < 10'(TOP_MARGIN);
  assign wall = (bus.x < 10'(WALL_W))
             || (bus.x >= 10'(H_RES - WALL_W));

  logic [3:0] flash_cnt_q;

  // Flash counter: hit reloads, frames count it down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      flash_cnt_q <= 4'd0;
    end else if (bus.hit_pulse) begin
      flash_cnt_q <= 4'(FLASH_FRAMES);
    end else if (bus.frame_tick && flash_cnt_q != 4'd0) begin
      flash_cnt_q <= flash_cnt_q - 4'd1;
    end
  end

  logic ovl_vis;

`ifdef GAMEOVER_BLINK_EN
  logic [5:0] blink_cnt_q;
  logic       blink_phase_q;

  // Blink timer: phase flips every BLINK_FRAMES frames of game over.
  always_ff @(posedge clk) begin
    if (reset || !bus.game_over) begin
      blink_cnt_q   <= 6'd0;
      blink_phase_q <= 1'b0;
    end else if (bus.frame_tick) begin
      if (blink_cnt_q == 6'(BLINK_FRAMES - 1)) begin
        blink_cnt_q   <= 6'd0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 6'd1;
      end
    end
  end

  assign ovl_vis = ~blink_phase_q;
`else
  assign ovl_vis = 1'b1;
`endif

  logic [11:0] spd_rgb, ball_rgb_d;

  // Ball colour by speed, overridden while flashing.
  always_comb begin
    spd_rgb = 12'hFFF;
    unique case (1'b1)
      (bus.ball_speed >= 4'd5): spd_rgb = 12'hF00;
      (bus.ball_speed == 4'd4): spd_rgb = 12'h0F0;
      (bus.ball_speed == 4'd3): spd_rgb = 12'h00F;
      default:                  spd_rgb = 12'hFFF;
    endcase
    ball_rgb_d = (flash_cnt_q != 4'd0) ? FLASH_COLOR : spd_rgb;
  end

  logic        v1_q, hdr1_q, wall1_q, pad1_q, ball1_q;
  logic        go1_q, txton1_q;
  logic [2:0]  row1_q, col1_q;
  logic [11:0] ballc1_q, txt1_q, bg1_q, gop1_q;

  // Stage 1: register sources and geometry hit flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q     <= 1'b0;
      hdr1_q   <= 1'b0;
      wall1_q  <= 1'b0;
      pad1_q   <= 1'b0;
      ball1_q  <= 1'b0;
      go1_q    <= 1'b0;
      txton1_q <= 1'b0;
      row1_q   <= 3'd0;
      col1_q   <= 3'd0;
      ballc1_q <= 12'h000;
      txt1_q   <= 12'h000;
      bg1_q    <= 12'h000;
      gop1_q   <= 12'h000;
    end else if (bus.pixel_tick) begin
      v1_q     <= bus.video_on;
      hdr1_q   <= hdr;
      wall1_q  <= wall;
      pad1_q   <= |pad_hit;
      ball1_q  <= ball_sq;
      go1_q    <= bus.game_over & ovl_vis;
      txton1_q <= bus.text_on;
      row1_q   <= rom_row;
      col1_q   <= rom_col;
      ballc1_q <= ball_rgb_d;
      txt1_q   <= bus.text_rgb;
      bg1_q    <= bus.bg_pixel;
      gop1_q   <= bus.game_over_pixel;
    end
  end

  logic [7:0] rom_line;

  // 8x8 round ball bitmap.
  always_comb begin
    rom_line = 8'hFF;
    case (row1_q)
      3'd0, 3'd7: rom_line = 8'h3C;
      3'd1, 3'd6: rom_line = 8'h7E;
      default:    rom_line = 8'hFF;
    endcase
  end

  logic        ball_bit;
  logic [11:0] rgb_d, rgb_q;
  assign ball_bit = ball1_q & rom_line[3'd7 - col1_q];

  // Stage 2 priority mux.
  always_comb begin
    rgb_d = bg1_q;
    if (!v1_q)         rgb_d = 12'h000;
    else if (hdr1_q)   rgb_d = txton1_q ? txt1_q
                                        : HEADER_BG_COLOR;
    else if (wall1_q)  rgb_d = WALL_COLOR;
    else if (go1_q)    rgb_d = gop1_q;
    else if (pad1_q)   rgb_d = PADDLE_COLOR;
    else if (ball_bit) rgb_d = ballc1_q;
    else               rgb_d = bg1_q;
  end

  // Stage 2 register drives the DAC.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= 12'h000;
    end else if (bus.pixel_tick) begin
      rgb_q <= rgb_d;
    end
  end

  assign bus.rgb = rgb_q;

endmodule

// File: tb/tb_pong_pixel_pipe.sv
// Bench for pong_pixel_pipe: directed plan steps then random pixels
// checked against a geometric reference model.
module tb_pong_pixel_pipe;

  localparam int NP = 3;
  localparam int BS = 2;
  localparam int FF = 6;
  localparam int BF = 2;
  localparam int TM = 25;
  localparam int WW = 32;
  localparam int HR = 640;
  localparam int PW = 9;
  localparam int PH = 73;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  pong_pixel_pipe_if #(.NUM_PADDLES(NP)) bus ();

  pong_pixel_pipe #(
    .NUM_PADDLES (NP),
    .BALL_SCALE  (BS),
    .FLASH_FRAMES(FF),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int hit_age   = 99;
  int go_frames = 0;

  function automatic logic [11:0] spd_col(int s);
    if (s >= 5) return 12'hF00;
    if (s == 4) return 12'h0F0;
    if (s == 3) return 12'h00F;
    return 12'hFFF;
  endfunction

  function automatic bit rom_bit(int r, int c);
    logic [7:0] rows [8];
    rows = '{8'h3C, 8'h7E, 8'hFF, 8'hFF,
             8'hFF, 8'hFF, 8'h7E, 8'h3C};
    return rows[r][7-c];
  endfunction

  function automatic logic [11:0] model();
    int xi;
    int yi;
    int dx;
    int dy;
    bit vis;
    xi = int'(bus.x);
    yi = int'(bus.y);
    if (!bus.video_on) return 12'h000;
    if (yi < TM) return bus.text_on ? bus.text_rgb : 12'h135;
    if (xi < WW || xi >= HR - WW) return 12'h89C;
`ifdef GAMEOVER_BLINK_EN
    vis = ((go_frames / BF) % 2) == 0;
`else
    vis = 1'b1;
`endif
    if (bus.game_over && vis) return bus.game_over_pixel;
    for (int i = 0; i < NP; i++) begin
      int px;
      int py;
      px = int'(bus.paddle_x[10*i +: 10]);
      py = int'(bus.paddle_y[10*i +: 10]) + TM;
      if (xi >= px && xi < px + PW && yi >= py && yi < py + PH)
        return 12'h24F;
    end
    dx = xi - int'(bus.ball_x);
    dy = yi - int'(bus.ball_y);
    if (dx >= 0 && dx < 8*BS && dy >= 0 && dy < 8*BS
        && rom_bit(dy / BS, dx / BS))
      return (hit_age < FF) ? 12'hFF0
                            : spd_col(int'(bus.ball_speed));
    return bus.bg_pixel;
  endfunction

  task automatic chk(string tag, logic [11:0] exp);
    total++;
    assert (bus.rgb === exp) else begin
      bad++;
      $error("FAIL %s rgb=%h expected=%h", tag, bus.rgb, exp);
    end
  endtask

  task automatic px_chk(string tag, logic [11:0] exp);
    bus.pixel_tick = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.pixel_tick = 1'b0;
    chk(tag, exp);
  endtask

  task automatic pulse(bit h, bit f);
    bus.hit_pulse  = h;
    bus.frame_tick = f;
    @(posedge clk);
    #1;
    bus.hit_pulse  = 1'b0;
    bus.frame_tick = 1'b0;
    if (f && bus.game_over) go_frames++;
    if (f && hit_age < 99) hit_age++;
    if (h) hit_age = 0;
  endtask

  task automatic set_go(bit g);
    bus.game_over = g;
    @(posedge clk);
    #1;
    if (!g) go_frames = 0;
  endtask

  task automatic at(int xv, int yv);
    bus.x = 10'(xv);
    bus.y = 10'(yv);
  endtask

  initial begin
    bus.pixel_tick      = 1'b0;
    bus.frame_tick      = 1'b0;
    bus.hit_pulse       = 1'b0;
    bus.game_over       = 1'b0;
    bus.video_on        = 1'b1;
    bus.text_on         = 1'b0;
    bus.text_rgb        = 12'h5A5;
    bus.bg_pixel        = 12'h123;
    bus.game_over_pixel = 12'hABC;
    bus.ball_x          = 10'd200;
    bus.ball_y          = 10'd200;
    bus.ball_speed      = 4'd4;
    bus.paddle_x        = {10'd500, 10'd300, 10'd32};
    bus.paddle_y        = {10'd0, 10'd50, 10'd100};
    at(100, 100);

    bus.pixel_tick = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 12'h000);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("lat_tick1", 12'h000);
    @(posedge clk);
    #1;
    chk("lat_tick2", 12'h123);
    bus.pixel_tick = 1'b0;

    at(100, 10);  px_chk("hdr_bg", 12'h135);
    bus.text_on = 1'b1;
    px_chk("hdr_text", 12'h5A5);
    bus.text_on = 1'b0;
    at(100, 24);  px_chk("hdr_last", 12'h135);
    at(5, 30);    px_chk("wall_l", 12'h89C);
    at(620, 30);  px_chk("wall_r", 12'h89C);
    at(31, 30);   px_chk("wall_l_edge", 12'h89C);
    at(32, 30);   px_chk("wall_l_out", 12'h123);
    at(607, 30);  px_chk("wall_r_out", 12'h123);
    at(608, 30);  px_chk("wall_r_edge", 12'h89C);

    at(300, 100); px_chk("pad_in", 12'h24F);
    at(300, 74);  px_chk("pad_above", 12'h123);
    at(300, 75);  px_chk("pad_top", 12'h24F);
    at(300, 147); px_chk("pad_bot", 12'h24F);
    at(300, 148); px_chk("pad_below", 12'h123);
    at(308, 100); px_chk("pad_right", 12'h24F);
    at(309, 100); px_chk("pad_outr", 12'h123);
    at(40, 150);  px_chk("pad0", 12'h24F);

    at(200, 200); px_chk("ball_corner", 12'h123);
    at(207, 207); px_chk("ball_mid", 12'h0F0);
    at(215, 216); px_chk("ball_out", 12'h123);
    at(204, 200); px_chk("ball_row0", 12'h0F0);
    at(203, 200); px_chk("ball_row0_off", 12'h123);
    at(207, 207);
    bus.ball_speed = 4'd3;  px_chk("spd3", 12'h00F);
    bus.ball_speed = 4'd5;  px_chk("spd5", 12'hF00);
    bus.ball_speed = 4'd15; px_chk("spd15", 12'hF00);
    bus.ball_speed = 4'd2;  px_chk("spd2", 12'hFFF);
    bus.ball_speed = 4'd0;  px_chk("spd0", 12'hFFF);
    bus.ball_speed = 4'd4;

    pulse(1'b1, 1'b0);
    px_chk("flash_hit", 12'hFF0);
    for (int i = 1; i <= 5; i++) begin
      pulse(1'b0, 1'b1);
      px_chk("flash_hold", 12'hFF0);
    end
    pulse(1'b0, 1'b1);
    px_chk("flash_end", 12'h0F0);
    pulse(1'b1, 1'b0);
    repeat (4) pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    repeat (5) pulse(1'b0, 1'b1);
    px_chk("flash_reload", 12'hFF0);
    pulse(1'b0, 1'b1);
    px_chk("flash_reload_end", 12'h0F0);

    set_go(1'b1);
    px_chk("go_vis", 12'hABC);
    at(5, 207);
    px_chk("go_wall", 12'h89C);
    at(207, 207);
    pulse(1'b0, 1'b1);
    px_chk("go_f1", 12'hABC);
    pulse(1'b0, 1'b1);
`ifdef GAMEOVER_BLINK_EN
    px_chk("go_blink_off", 12'h0F0);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    px_chk("go_blink_on", 12'hABC);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    px_chk("go_blink_off2", 12'h0F0);
    set_go(1'b0);
    set_go(1'b1);
    px_chk("go_restart", 12'hABC);
`else
    px_chk("go_steady", 12'hABC);
`endif
    set_go(1'b0);
    px_chk("go_off", 12'h0F0);

    pulse(1'b1, 1'b0);
    bus.pixel_tick = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    hit_age = 99;
    chk("rst_mid", 12'h000);
    @(posedge clk);
    #1;
    chk("rst_mid_t1", 12'h000);
    @(posedge clk);
    #1;
    bus.pixel_tick = 1'b0;
    chk("rst_flash_clr", 12'h0F0);

    for (int n = 0; n < 80; n++) begin
      int mode;
      int k;
      int r;
      bus.video_on        = ($urandom_range(0, 9) != 0);
      bus.text_on         = 1'($urandom_range(0, 1));
      bus.text_rgb        = 12'($urandom);
      bus.bg_pixel        = 12'($urandom);
      bus.game_over_pixel = 12'($urandom);
      bus.ball_x          = 10'($urandom_range(40, 580));
      bus.ball_y          = 10'($urandom_range(30, 440));
      bus.ball_speed      = 4'($urandom);
      for (int i = 0; i < NP; i++) begin
        bus.paddle_x[10*i +: 10] = 10'($urandom_range(0, 630));
        bus.paddle_y[10*i +: 10] = 10'($urandom_range(0, 400));
      end
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        at(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
      end else if (mode == 1) begin
        at(int'(bus.ball_x) - 1 + int'($urandom_range(0, 18)),
           int'(bus.ball_y) - 1 + int'($urandom_range(0, 18)));
      end else begin
        k = int'($urandom_range(0, NP - 1));
        at(int'(bus.paddle_x[10*k +: 10]) + int'($urandom_range(0, PW + 1)),
           int'(bus.paddle_y[10*k +: 10]) + TM - 1
             + int'($urandom_range(0, PH + 1)));
      end
      r = int'($urandom_range(0, 7));
      if (r == 0) pulse(1'b1, 1'b0);
      if (r == 1) pulse(1'b0, 1'b1);
      if (r == 2) pulse(1'b1, 1'b1);
      if (r == 3) set_go(~bus.game_over);
      px_chk("rnd", model());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pong_pixel_pipe.md
# pong_pixel_pipe

Registered, parametrised pixel compositor for the Pong VGA datapath. It sits between the VGA sync generator and the DAC pins. It merges the header text, walls, N paddles, a scalable round ball, the game-over overlay and the background into one 12-bit RGB stream through a 2-stage pipeline. It adds frame-timed ball hit-flash and optional game-over blinking.

## Interface
Parameters:
- NUM_PADDLES, 2: number of paddles; index 0 has highest draw priority.
- PADDLE_W, 9: paddle width in pixels.
- PADDLE_H, 73: paddle height in pixels.
- BALL_SCALE, 1: ball magnification; legal values 1, 2, 4; ball square = 8*BALL_SCALE.
- TOP_MARGIN, 25: header height in rows.
- WALL_W, 32: width of each side wall.
- H_RES, 640: active width; right wall covers x >= H_RES-WALL_W.
- FLASH_FRAMES, 6: frames the ball flashes after a hit; 1..15.
- BLINK_FRAMES, 30: half-period of game-over blink, in frames; 1..63.
- WALL_COLOR 12'h89C, PADDLE_COLOR 12'h24F, HEADER_BG_COLOR 12'h135, FLASH_COLOR 12'hFF0.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- pixel_tick  in  1  pipeline advance enable, one per pixel.
- frame_tick  in  1  one-clk pulse per frame, at the start of vertical blank.
- x, y  in  10 each  current pixel coordinates.
- video_on  in  1  active-video flag.
- ball_x, ball_y  in  10 each  top-left of the ball square.
- paddle_x  in  10*NUM_PADDLES  packed paddle left columns; paddle i is at [10*i+9:10*i].
- paddle_y  in  10*NUM_PADDLES  packed paddle top rows, relative to TOP_MARGIN.
- ball_speed  in  4  selects ball colour.
- hit_pulse  in  1  one-clk pulse on a paddle/ball collision.
- game_over  in  1  level; enables the overlay.
- bg_pixel, game_over_pixel, text_rgb  in  12 each  pixel sources.
- text_on  in  1  header text foreground.
- rgb  out  12  registered pixel; reset value 12'h000.

## Operation
- Stage 1, on pixel_tick:
  - Register video_on, x, y, and the three pixel sources with text_on.
  - Compute and register the hit flags: header, left wall, right wall, paddle[i], ball square, ball ROM row/col.
- Paddle i hit condition:
  - paddle_x_i <= x <= paddle_x_i+PADDLE_W-1, and
  - paddle_y_i+TOP_MARGIN <= y <= paddle_y_i+TOP_MARGIN+PADDLE_H-1.
  - All sums are evaluated at 11 bits, so there is no wrap.
- Ball:
  - dx = x-ball_x and dy = y-ball_y, full width.
  - Square hit when 0 <= dx,dy < 8*BALL_SCALE.
  - ROM row = dy>>log2(BALL_SCALE); col = dx>>log2(BALL_SCALE).
  - ROM is an 8x8 circle, rows 0..7: 3C,7E,FF,FF,FF,FF,7E,3C.
- Stage 2, on pixel_tick, priority mux into rgb:
  1. !video_on → 000.
  2. y<TOP_MARGIN → text_rgb if text_on, else HEADER_BG_COLOR.
  3. Wall → WALL_COLOR.
  4. game_over and overlay visible → game_over_pixel.
  5. Any paddle → PADDLE_COLOR.
  6. Ball bit set → ball colour.
  7. Otherwise → bg_pixel.
- Ball colour:
  - FLASH_COLOR while flash_cnt != 0.
  - Otherwise by ball_speed: 2 → FFF, 3 → 00F, 4 → 0F0, >=5 → F00, 0/1 → FFF.
- flash_cnt (4-bit):
  - hit_pulse loads FLASH_FRAMES.
  - frame_tick decrements it while nonzero; it holds at 0.
  - If hit_pulse and frame_tick arrive in the same clk, the load wins.
- Overlay visible: always 1, except when GAMEOVER_BLINK_EN is set (see Configuration).

## Timing
- Latency: rgb for pixel (x,y) appears 2 pixel_ticks after sampling. The sync generator delays hsync/vsync by 2 ticks.
- The pipeline holds when pixel_tick = 0. Counters update on every clk regardless of pixel_tick.
- frame_tick and hit_pulse change only the colour of pixels sampled in later clks; the pixel currently in flight is unaffected.
- Reset clears both pipeline stages (video_on flags = 0, so rgb = 000), flash_cnt, blink_cnt and blink_phase. Reset during active video gives black for the next 2 ticks.
- Parameter values outside their stated legal ranges are unsupported.

## Configuration
- Macro GAMEOVER_BLINK_EN.
- Defined:
  - blink_cnt (6-bit) increments on frame_tick while game_over = 1.
  - When blink_cnt reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - Overlay is visible when blink_phase = 0.
  - When invisible, pixels fall through to paddles, ball and bg.
  - game_over = 0 clears blink_cnt and blink_phase.
- Undefined: the overlay is steady, and the blink counter and phase logic are not instantiated.

## Test plan
- Reset, then video_on = 1, x = 100, y = 100, bg_pixel = 123 → rgb = 000 until 2 pixel_ticks after reset release, then 123.
- Header and wall priority: y = 10, text_on = 0 → 135. Then y = 30, x = 5 → 89C. Then x = 620 → 89C. Each appears at 2-tick latency.
- NUM_PADDLES = 3, paddle_x = {500,300,32}, paddle_y = {0,50,100}, sampled at x = 300, y = 75+TOP_MARGIN → 24F. At x = 300, y = 74 → bg_pixel, because the top edge is y = 75 (50+TOP_MARGIN).
- BALL_SCALE = 2, ball at (200,200), ball_speed = 4:
  - (200,200) → bg (ROM corner bit 0).
  - (207,207) → 0F0.
  - (215,216) → bg (outside the square).
- hit_pulse, then 6 frame_ticks: ball pixel = FF0 through the 5th frame_tick, 0F0 after the 6th. hit_pulse coincident with a frame_tick reloads to 6.
- With GAMEOVER_BLINK_EN, BLINK_FRAMES = 2, game_over = 1: overlay pixel alternates game_over_pixel/bg every 2 frame_ticks. Dropping game_over resets the phase so the overlay is visible immediately.
